// File: rtl/fc_train_ctrl.sv
// Training sequencer for the fully-connected memory: runs FC1, FC2, writes the
// one-hot target, waits out back-propagation and triggers per-batch weight updates.
module fc_train_ctrl #(
  parameter int          BCK_CELL   = 10,
  parameter int          BATCH_SIZE = 32,
  parameter int          NUM_BATCH  = 16,
  parameter int          LABEL_W    = 4,
  parameter logic [15:0] ONE_VAL    = 16'h0600
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               sample_valid_i,
  output logic               sample_ready_o,
  input  logic [LABEL_W-1:0] label_i,
  output logic               fc1_go_o,
  input  logic               fc1_done_i,
  output logic               fc2_go_o,
  input  logic               fc2_done_i,
  output logic               fc1_com_end_o,
  output logic               fc2_com_end_o,
  output logic               lbl_we_o,
  output logic [15:0]        lbl_addr_o,
  output logic [15:0]        lbl_data_o,
  output logic               bck_prop_start_o,
  input  logic               fc_bck_prop_end_i,
  output logic               batch_end_o,
  input  logic               fc_batch_end_i,
  output logic [5:0]         sample_cnt_o,
  output logic [15:0]        batch_cnt_o,
  output logic               busy_o,
  output logic               train_done_o,
  output logic               label_err_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // WAIT_S | sample_ready high, waiting for a loaded sample
  // FC1    | FC1 engine running (go on first cycle)
  // FC2    | FC2 engine running (go on first cycle)
  // LABEL  | writing BCK_CELL target entries
  // BACK   | back-propagation enabled, waiting for memory
  // UPDATE | weight update enabled, waiting for memory
  // DONE   | one-cycle train_done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FC1, S_FC2, S_LABEL, S_BACK, S_UPDATE, S_DONE
  } state_t;

  localparam logic [15:0] CELLS  = 16'(BCK_CELL);
  localparam logic [15:0] LAST_K = 16'(BCK_CELL - 1);
  localparam logic [5:0]  LAST_S = 6'(BATCH_SIZE - 1);
  localparam logic [15:0] NB     = 16'(NUM_BATCH);

  state_t      state_q;
  logic [15:0] label_q;
  logic [15:0] k_q;
  logic        sample_ready_q, fc1_go_q, fc2_go_q, c1_q, c2_q, lbl_we_q;
  logic [15:0] lbl_addr_q, lbl_data_q;
  logic        bck_q, batch_end_q, train_done_q, label_err_q;
  logic [5:0]  sample_cnt_q;
  logic [15:0] batch_cnt_q;

  logic [15:0] label_ext_d;
  logic [15:0] k_d;
  logic [15:0] batch_cnt_d;

  always_comb begin
    label_ext_d = 16'(label_i);
    k_d         = k_q + 16'd1;
    batch_cnt_d = batch_cnt_q + 16'd1;
  end

  // The go pulse doubles as the first-cycle marker, so done is only honoured
  // once the go pulse has been retired.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      label_q        <= '0;
      k_q            <= '0;
      sample_ready_q <= 1'b0;
      fc1_go_q       <= 1'b0;
      fc2_go_q       <= 1'b0;
      c1_q           <= 1'b0;
      c2_q           <= 1'b0;
      lbl_we_q       <= 1'b0;
      lbl_addr_q     <= '0;
      lbl_data_q     <= '0;
      bck_q          <= 1'b0;
      batch_end_q    <= 1'b0;
      train_done_q   <= 1'b0;
      label_err_q    <= 1'b0;
      sample_cnt_q   <= '0;
      batch_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sample_ready_q <= 1'b1;
            sample_cnt_q   <= '0;
            batch_cnt_q    <= '0;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sample_valid_i) begin
            label_q        <= label_ext_d;
            if (label_ext_d >= CELLS) label_err_q <= 1'b1;
            c1_q           <= 1'b0;
            c2_q           <= 1'b0;
            sample_ready_q <= 1'b0;
            fc1_go_q       <= 1'b1;
            state_q        <= S_FC1;
          end
        end
        S_FC1: begin
          if (fc1_go_q) begin
            fc1_go_q <= 1'b0;
          end else if (fc1_done_i) begin
            c1_q     <= 1'b1;
            fc2_go_q <= 1'b1;
            state_q  <= S_FC2;
          end
        end
        S_FC2: begin
          if (fc2_go_q) begin
            fc2_go_q <= 1'b0;
          end else if (fc2_done_i) begin
            c2_q       <= 1'b1;
            k_q        <= '0;
            lbl_we_q   <= 1'b1;
            lbl_addr_q <= CELLS;
            lbl_data_q <= (label_q == 16'd0) ? ONE_VAL : 16'h0000;
            state_q    <= S_LABEL;
          end
        end
        S_LABEL: begin
          if (k_q == LAST_K) begin
            lbl_we_q <= 1'b0;
            bck_q    <= 1'b1;
            state_q  <= S_BACK;
          end else begin
            k_q        <= k_d;
            lbl_addr_q <= CELLS + k_d;
            lbl_data_q <= (label_q == k_d) ? ONE_VAL : 16'h0000;
          end
        end
        S_BACK: begin
          if (fc_bck_prop_end_i) begin
            bck_q <= 1'b0;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
            if (sample_cnt_q == LAST_S) begin
              sample_cnt_q <= '0;
              batch_end_q  <= 1'b1;
              state_q      <= S_UPDATE;
            end else begin
              sample_cnt_q   <= sample_cnt_q + 6'd1;
              sample_ready_q <= 1'b1;
              state_q        <= S_WAIT;
            end
          end
        end
        S_UPDATE: begin
          if (fc_batch_end_i) begin
            batch_end_q <= 1'b0;
            batch_cnt_q <= batch_cnt_d;
            if (batch_cnt_d == NB) begin
              train_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              sample_ready_q <= 1'b1;
              state_q        <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          train_done_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_ready_o   = sample_ready_q;
  assign fc1_go_o         = fc1_go_q;
  assign fc2_go_o         = fc2_go_q;
  assign fc1_com_end_o    = c1_q;
  assign fc2_com_end_o    = c2_q;
  assign lbl_we_o         = lbl_we_q;
  assign lbl_addr_o       = lbl_addr_q;
  assign lbl_data_o       = lbl_data_q;
  assign bck_prop_start_o = bck_q;
  assign batch_end_o      = batch_end_q;
  assign sample_cnt_o     = sample_cnt_q;
  assign batch_cnt_o      = batch_cnt_q;
  assign busy_o           = (state_q != S_IDLE);
  assign train_done_o     = train_done_q;
  assign label_err_o      = label_err_q;

endmodule

// File: tb/tb_fc_train_ctrl.sv
// Randomized bench for fc_train_ctrl: a phase-level model of the training
// sequence predicts every output each cycle; literal pins anchor the model.
module tb_fc_train_ctrl;
  localparam int          BCK = 10;
  localparam int          BS  = 32;
  localparam int          NB  = 2;
  localparam logic [15:0] ONE = 16'h0600;

  typedef enum int {P_IDLE, P_WAIT, P_FC1, P_FC2, P_LABEL, P_BACK, P_UPD, P_DONE} phase_t;
  localparam int K_NONE = -1, K_ST = 0, K_SV = 1, K_D1 = 2, K_D2 = 3, K_BP = 4, K_BE = 5;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sv = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0, bpe = 1'b0, be = 1'b0;
  logic [3:0] label = 4'd0;

  logic        sample_ready, fc1_go, fc2_go, fc1_com_end, fc2_com_end, lbl_we;
  logic [15:0] lbl_addr, lbl_data, batch_cnt;
  logic        bck_prop_start, batch_end, busy, train_done, label_err;
  logic [5:0]  sample_cnt;

  fc_train_ctrl #(.BCK_CELL(BCK), .BATCH_SIZE(BS), .NUM_BATCH(NB), .LABEL_W(4), .ONE_VAL(ONE)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sample_valid_i(sv),
    .sample_ready_o(sample_ready), .label_i(label),
    .fc1_go_o(fc1_go), .fc1_done_i(d1), .fc2_go_o(fc2_go), .fc2_done_i(d2),
    .fc1_com_end_o(fc1_com_end), .fc2_com_end_o(fc2_com_end),
    .lbl_we_o(lbl_we), .lbl_addr_o(lbl_addr), .lbl_data_o(lbl_data),
    .bck_prop_start_o(bck_prop_start), .fc_bck_prop_end_i(bpe),
    .batch_end_o(batch_end), .fc_batch_end_i(be),
    .sample_cnt_o(sample_cnt), .batch_cnt_o(batch_cnt), .busy_o(busy),
    .train_done_o(train_done), .label_err_o(label_err)
  );

  always #5 clk = ~clk;

  // model of the current cycle, written only by the stimulus process
  phase_t ph = P_IDLE;
  bit     first = 1'b0, m_c1 = 1'b0, m_c2 = 1'b0, m_lerr = 1'b0;
  int     m_k = 0, m_scnt = 0, m_bcnt = 0, m_label = 0;
  bit     chk_en = 1'b0;
  int     bck_hi = 0, data_sum = 0;

  string       pin_name [128];
  logic [15:0] pin_act  [128];
  logic [15:0] pin_exp  [128];
  int          pin_n = 0, pin_seen = 0;

  int errors = 0, checks = 0;

  task automatic cmp(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("sample_ready", 16'(sample_ready), 16'(ph == P_WAIT));
      cmp("fc1_go", 16'(fc1_go), 16'(ph == P_FC1 && first));
      cmp("fc2_go", 16'(fc2_go), 16'(ph == P_FC2 && first));
      cmp("com_end", {14'd0, fc1_com_end, fc2_com_end}, {14'd0, m_c1, m_c2});
      cmp("lbl_we", 16'(lbl_we), 16'(ph == P_LABEL));
      if (ph == P_LABEL) begin
        cmp("lbl_addr", lbl_addr, 16'(BCK + m_k));
        cmp("lbl_data", lbl_data, (m_k == m_label) ? ONE : 16'h0000);
      end
      cmp("bck_prop_start", 16'(bck_prop_start), 16'(ph == P_BACK));
      cmp("batch_end", 16'(batch_end), 16'(ph == P_UPD));
      cmp("sample_cnt", {10'd0, sample_cnt}, 16'(m_scnt));
      cmp("batch_cnt", batch_cnt, 16'(m_bcnt));
      cmp("busy", 16'(busy), 16'(ph != P_IDLE));
      cmp("train_done", 16'(train_done), 16'(ph == P_DONE));
      cmp("label_err", 16'(label_err), 16'(m_lerr));
    end
    while (pin_seen < pin_n) begin
      cmp(pin_name[pin_seen], pin_act[pin_seen], pin_exp[pin_seen]);
      pin_seen++;
    end
  end

  task automatic pin(input string n, input logic [15:0] a, input logic [15:0] e);
    pin_name[pin_n] = n;
    pin_act[pin_n]  = a;
    pin_exp[pin_n]  = e;
    pin_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // randomize every input that the current phase must ignore
  task automatic strays(input int keep);
    if (keep != K_ST) start = 1'($urandom_range(0, 1));
    if (keep != K_SV) begin sv = 1'($urandom_range(0, 1)); label = 4'($urandom_range(0, 15)); end
    if (keep != K_D1) d1 = 1'($urandom_range(0, 1));
    if (keep != K_D2) d2 = 1'($urandom_range(0, 1));
    if (keep != K_BP) bpe = 1'($urandom_range(0, 1));
    if (keep != K_BE) be = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    strays(K_NONE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ph = P_IDLE; first = 0; m_c1 = 0; m_c2 = 0; m_lerr = 0;
    m_k = 0; m_scnt = 0; m_bcnt = 0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin strays(K_ST); start = 1'b0; tick(); end
  endtask

  task automatic do_start();
    strays(K_ST); start = 1'b1; tick();
    ph = P_WAIT; m_bcnt = 0; m_scnt = 0;
  endtask

  task automatic run_sample(input int lab, input int wv, input int dl1, input int dl2,
                            input int dbp, input bit abort_back);
    repeat (wv) begin strays(K_SV); sv = 1'b0; tick(); end
    strays(K_SV); sv = 1'b1; label = 4'(lab); tick();
    ph = P_FC1; first = 1; m_c1 = 0; m_c2 = 0; m_label = lab;
    if (lab >= BCK) m_lerr = 1;
    strays(K_NONE); tick(); first = 0;
    repeat (dl1) begin strays(K_D1); d1 = 1'b0; tick(); end
    strays(K_D1); d1 = 1'b1; tick();
    ph = P_FC2; first = 1; m_c1 = 1;
    strays(K_NONE); tick(); first = 0;
    repeat (dl2) begin strays(K_D2); d2 = 1'b0; tick(); end
    strays(K_D2); d2 = 1'b1; tick();
    ph = P_LABEL; m_k = 0; m_c2 = 1; data_sum = 0;
    for (int i = 0; i < BCK; i++) begin
      data_sum += int'(lbl_data);
      strays(K_NONE); tick();
      if (i < BCK - 1) m_k = i + 1;
      else ph = P_BACK;
    end
    bck_hi = 0;
    if (abort_back) begin
      bck_hi += int'(bck_prop_start);
      strays(K_BP); bpe = 1'b0; tick();
      do_reset();
      return;
    end
    repeat (dbp) begin
      bck_hi += int'(bck_prop_start);
      strays(K_BP); bpe = 1'b0; tick();
    end
    bck_hi += int'(bck_prop_start);
    strays(K_BP); bpe = 1'b1; tick();
    m_c1 = 0; m_c2 = 0;
    if (m_scnt == BS - 1) begin m_scnt = 0; ph = P_UPD; end
    else begin m_scnt++; ph = P_WAIT; end
  endtask

  task automatic run_random(input int n);
    for (int s = 0; s < n; s++)
      run_sample($urandom_range(0, BCK - 1), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 6), 1'b0);
  endtask

  task automatic run_update(input int dly, input bit abort);
    repeat (dly) begin strays(K_BE); be = 1'b0; tick(); end
    if (abort) begin do_reset(); return; end
    strays(K_BE); be = 1'b1; tick();
    m_bcnt++;
    ph = (m_bcnt == NB) ? P_DONE : P_WAIT;
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    pin("rst_lbl_addr", lbl_addr, 16'd0);
    pin("rst_batch_cnt", batch_cnt, 16'd0);
    idle_cyc(6);
    do_start();

    // first sample: label 3, back-prop held 50 cycles
    run_sample(3, 1, 0, 0, 50, 1'b0);
    pin("target_sum_label3", 16'(data_sum), 16'h0600);
    pin("bck_high_cycles", 16'(bck_hi), 16'd51);
    pin("sample_cnt_after_first", {10'd0, sample_cnt}, 16'd1);
    pin("ready_after_first", 16'(sample_ready), 16'd1);
    pin("com_end_after_back", {14'd0, fc1_com_end, fc2_com_end}, 16'd0);

    for (int s = 1; s < BS; s++) begin
      if (s == 5) begin
        run_sample(12, 0, 1, 0, 2, 1'b0);
        pin("label_err_set", 16'(label_err), 16'd1);
        pin("target_sum_oor", 16'(data_sum), 16'd0);
      end else begin
        run_random(1);
      end
    end
    pin("batch_end_after_32", 16'(batch_end), 16'd1);
    pin("sample_cnt_wrap", {10'd0, sample_cnt}, 16'd0);
    run_update(640, 1'b0);
    pin("batch_cnt_one", batch_cnt, 16'd1);
    pin("ready_after_update", 16'(sample_ready), 16'd1);

    run_random(BS);
    run_update($urandom_range(0, 5), 1'b0);
    pin("train_done_pulse", 16'(train_done), 16'd1);
    strays(K_NONE); tick();
    ph = P_IDLE;
    pin("train_done_single", 16'(train_done), 16'd0);
    pin("busy_after_done", 16'(busy), 16'd0);
    pin("batch_cnt_hold", batch_cnt, 16'(NB));

    idle_cyc(4);
    do_start();
    pin("batch_cnt_cleared", batch_cnt, 16'd0);
    pin("label_err_sticky", 16'(label_err), 16'd1);

    run_sample(7, 0, 0, 1, 0, 1'b1);
    pin("abort_back_bck", 16'(bck_prop_start), 16'd0);
    pin("abort_back_busy", 16'(busy), 16'd0);
    pin("abort_back_lerr", 16'(label_err), 16'd0);
    idle_cyc(5);

    do_start();
    run_random(BS);
    run_update(3, 1'b1);
    pin("abort_upd_batch_end", 16'(batch_end), 16'd0);
    pin("abort_upd_busy", 16'(busy), 16'd0);
    idle_cyc(5);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
